// File: rtl/tile_map_server.sv
// Maze tile RAM server: builds the starting layout after reset, then serves
// one read/write request at a time. Optional score output under TILE_MAP_SCORE_EN.
module tile_map_server #(
  parameter int MAP_W = 24,
  parameter int MAP_H = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [4:0] req_x,
  input  logic [4:0] req_y,
  input  logic [2:0] req_data,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [2:0] rsp_sprite,
  output logic [9:0] dots_left,
  output logic       level_clear,
  output logic       init_done
`ifdef TILE_MAP_SCORE_EN
  ,output logic [15:0] score
`endif
);
  localparam int DEPTH = MAP_W * MAP_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [4:0]    XL       = 5'(MAP_W - 1);
  localparam logic [4:0]    YL       = 5'(MAP_H - 1);
  localparam logic [5:0]    W6       = 6'(MAP_W);
  localparam logic [5:0]    H6       = 6'(MAP_H);
  localparam logic [AW-1:0] ALAST    = AW'(DEPTH - 1);
  localparam logic [9:0]    INTERIOR = 10'((MAP_W - 2) * (MAP_H - 2));
  localparam logic [2:0]    S_EMPTY  = 3'b000;
  localparam logic [2:0]    S_PELLET = 3'b001;
  localparam logic [2:0]    S_DOT    = 3'b010;
  localparam logic [2:0]    S_WALL   = 3'b011;

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;

  logic [2:0]    mem [DEPTH];
  logic [4:0]    ix_q, ix_d, iy_q, iy_d;
  logic [AW-1:0] iaddr_q, iaddr_d, addr_q, addr_d;
  logic          wr_q, wr_d, inr_q, inr_d, done_q, done_d;
  logic [2:0]    data_q, data_d, rsp_q, rsp_d;
  logic [9:0]    dots_q, dots_d;

  logic          we;
  logic [AW-1:0] wa;
  logic [2:0]    wd, rd;
  logic [10:0]   lin;
  logic          border_t, corner_t;

  function automatic logic is_dot(input logic [2:0] v);
    return (v == S_DOT) || (v == S_PELLET);
  endfunction

  assign lin      = 11'(req_y) * 11'(MAP_W) + 11'(req_x);
  assign border_t = (ix_q == 5'd0) || (iy_q == 5'd0) || (ix_q == XL) || (iy_q == YL);
  assign corner_t = ((ix_q == 5'd1) || (ix_q == XL - 5'd1)) &&
                    ((iy_q == 5'd1) || (iy_q == YL - 5'd1));
  // Out-of-range requests never touch the RAM and always see a wall
  assign rd       = inr_q ? mem[addr_q] : S_WALL;

  always_comb begin
    state_d = state_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    iaddr_d = iaddr_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    inr_d   = inr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    dots_d  = dots_q;
    done_d  = done_q;
    we      = 1'b0;
    wa      = addr_q;
    wd      = data_q;
    case (state_q)
      INIT: begin
        we      = 1'b1;
        wa      = iaddr_q;
        wd      = border_t ? S_WALL : (corner_t ? S_PELLET : S_DOT);
        iaddr_d = iaddr_q + 1'b1;
        if (ix_q == XL) begin
          ix_d = 5'd0;
          iy_d = iy_q + 5'd1;
        end else begin
          ix_d = ix_q + 5'd1;
        end
        if (iaddr_q == ALAST) begin
          state_d = IDLE;
          dots_d  = INTERIOR;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          addr_d  = lin[AW-1:0];
          inr_d   = ({1'b0, req_x} < W6) && ({1'b0, req_y} < H6);
          wr_d    = req_write;
          data_d  = req_data;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rsp_d   = rd;
        state_d = RESP;
        if (wr_q && inr_q) begin
          we = 1'b1;
          if (is_dot(rd) && !is_dot(data_q))      dots_d = dots_q - 10'd1;
          else if (!is_dot(rd) && is_dot(data_q)) dots_d = dots_q + 10'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (we && !reset) mem[wa] <= wd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      ix_q    <= '0;
      iy_q    <= '0;
      iaddr_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      inr_q   <= 1'b0;
      data_q  <= '0;
      rsp_q   <= '0;
      dots_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      iaddr_q <= iaddr_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      inr_q   <= inr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      dots_q  <= dots_d;
      done_q  <= done_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_sprite  = rsp_q;
  assign dots_left   = dots_q;
  assign init_done   = done_q;
  assign level_clear = done_q && (dots_q == 10'd0);

`ifdef TILE_MAP_SCORE_EN
  logic [15:0] score_q;
  logic [5:0]  score_inc;
  logic [16:0] score_sum;

  // Eating a dot or pellet means overwriting it with empty
  always_comb begin
    score_inc = 6'd0;
    if (state_q == ACCESS && wr_q && inr_q && data_q == S_EMPTY) begin
      if (rd == S_DOT)         score_inc = 6'd10;
      else if (rd == S_PELLET) score_inc = 6'd50;
    end
  end

  assign score_sum = {1'b0, score_q} + 17'(score_inc);

  always_ff @(posedge clock) begin
    if (reset) score_q <= '0;
    else       score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  assign score = score_q;
`endif
endmodule

// File: tb/tb_tile_map_server.sv
// Randomized scoreboard bench for tile_map_server against a tile-array model.
module tb_tile_map_server;
  localparam int W = 24;
  localparam int H = 24;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [4:0] req_x = '0;
  logic [4:0] req_y = '0;
  logic [2:0] req_data = '0;
  logic       req_ready, rsp_valid, level_clear, init_done;
  logic [2:0] rsp_sprite;
  logic [9:0] dots_left;
`ifdef TILE_MAP_SCORE_EN
  logic [15:0] score;
`endif

  always #5 clock = ~clock;

  tile_map_server #(.MAP_W(W), .MAP_H(H)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sprite(rsp_sprite),
    .dots_left(dots_left), .level_clear(level_clear), .init_done(init_done)
`ifdef TILE_MAP_SCORE_EN
    , .score(score)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] model [N];
  logic [2:0] exp_q [$];
  int exp_score = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_dot(input logic [2:0] v);
    return v == 3'b010 || v == 3'b001;
  endfunction

  function automatic int dot_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (is_dot(model[i])) c++;
    return c;
  endfunction

  function automatic void build_model();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (x == 0 || y == 0 || x == W-1 || y == H-1) model[y*W+x] = 3'b011;
        else if ((x == 1 || x == W-2) && (y == 1 || y == H-2)) model[y*W+x] = 3'b001;
        else model[y*W+x] = 3'b010;
      end
  endfunction

  // Monitor: every response strobe must match the oldest expected value
  always @(negedge clock) begin
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got %0d expected no response", rsp_sprite);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (rsp_sprite !== e) begin
          errors++;
          $display("FAIL rsp_sprite got %0d expected %0d", rsp_sprite, e);
        end
      end
    end
  end

  task automatic do_reset_init();
    @(negedge clock);
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sprite", rsp_sprite, 0);
    chk("rst_dots_left", dots_left, 0);
    chk("rst_level_clear", level_clear, 0);
    chk("rst_init_done", init_done, 0);
`ifdef TILE_MAP_SCORE_EN
    chk("rst_score", score, 0);
`endif
    exp_score = 0;
    reset = 1'b0;
    repeat (N - 1) @(posedge clock);
    @(negedge clock);
    chk("init_done_early", init_done, 0);
    @(negedge clock);
    build_model();
    chk("init_done_rise", init_done, 1);
    chk("init_dots_left", dots_left, dot_count());
    chk("init_level_clear", level_clear, 0);
    chk("init_req_ready", req_ready, 1);
  endtask

  // Issue one request starting at a negedge; returns at the T+3 negedge
  task automatic req(input bit w, input int x, input int y, input int d);
    int n = 0;
    bit inr;
    int idx;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", req_ready, 1);
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_x     = x[4:0];
    req_y     = y[4:0];
    req_data  = d[2:0];
    inr = (x < W) && (y < H);
    idx = y * W + x;
    if (!inr) exp_q.push_back(3'b011);
    else begin
      exp_q.push_back(model[idx]);
      if (w) begin
        if (d == 0 && model[idx] == 3'b010) exp_score += 10;
        if (d == 0 && model[idx] == 3'b001) exp_score += 50;
        if (exp_score > 65535) exp_score = 65535;
        model[idx] = d[2:0];
      end
    end
    @(negedge clock);
    chk("t1_req_ready", req_ready, 0);
    chk("t1_rsp_valid", rsp_valid, 0);
    req_write = 1'($urandom_range(0, 1));
    req_x     = 5'($urandom_range(0, 31));
    req_y     = 5'($urandom_range(0, 31));
    req_data  = 3'($urandom_range(0, 7));
    @(negedge clock);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_req_ready", req_ready, 0);
    @(negedge clock);
    req_valid = 1'b0;
    chk("t3_req_ready", req_ready, 1);
    chk("t3_rsp_valid", rsp_valid, 0);
    chk("dots_left", dots_left, dot_count());
    chk("level_clear", level_clear, dot_count() == 0);
`ifdef TILE_MAP_SCORE_EN
    chk("score", score, exp_score);
`endif
  endtask

  initial begin
    do_reset_init();

    req(0, 0, 0, 0);
    req(0, 1, 1, 0);
    req(0, 5, 7, 0);
    req(0, 22, 22, 0);

    req(1, 5, 7, 0);
    chk("dots_after_eat", dots_left, 483);
    req(0, 5, 7, 0);
    req(1, 1, 1, 0);
`ifdef TILE_MAP_SCORE_EN
    chk("score_60", score, 60);
`endif

    req(0, 30, 3, 0);
    req(1, 24, 0, 2);
    req(1, 3, 3, 0);
    req(1, 3, 3, 2);

    for (int i = 0; i < 150; i++) begin
      int x, y;
      if ($urandom_range(0, 3) != 0) begin
        x = $urandom_range(0, W - 1);
        y = $urandom_range(0, H - 1);
      end else begin
        x = $urandom_range(0, 31);
        y = $urandom_range(0, 31);
      end
      req(1'($urandom_range(0, 1)), x, y, $urandom_range(0, 7));
    end

    for (int y = 1; y < H - 1; y++)
      for (int x = 1; x < W - 1; x++) req(1, x, y, 0);
    for (int i = 0; i < N; i++)
      if (is_dot(model[i])) req(1, i % W, i / W, 0);
    chk("level_clear_all", level_clear, 1);
    req(1, 2, 2, 2);
    chk("unclear_dots", dots_left, 1);
    chk("unclear_level", level_clear, 0);

    // Reset one cycle after acceptance: the request must vanish
    req_valid = 1'b1;
    req_write = 1'b0;
    req_x = 5'd3;
    req_y = 5'd3;
    @(negedge clock);
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    do_reset_init();
    req(0, 5, 7, 0);
    req(0, 1, 1, 0);
    req(0, 2, 2, 0);
    req(0, 0, 0, 0);

    repeat (3) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
